// File: rtl/hazard_ctrl.sv
// Decode-side hazard controller for the 5-stage core: load-use and branch-operand stalls,
// taken-branch flush, EX operand forwarding selects and a saturating stall-cycle counter.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id_instr,
  input  logic [2:0]  id_dest,
  input  logic        id_branch_taken,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic [1:0]  fwd_rs1,
  output logic [1:0]  fwd_rs2,
  output logic [15:0] stall_count
);

  localparam logic [3:0] OpAddi = 4'd9;
  localparam logic [3:0] OpLd   = 4'd10;
  localparam logic [3:0] OpSt   = 4'd11;
  localparam logic [3:0] OpBz   = 4'd12;

  localparam logic [1:0] FwdRf  = 2'd0;
  localparam logic [1:0] FwdMem = 2'd1;
  localparam logic [1:0] FwdWb  = 2'd2;

  // Shadow of the instructions in EX, MEM and WB
  logic        ex_valid_q, mem_valid_q, wb_valid_q;
  logic [2:0]  ex_dest_q, mem_dest_q, wb_dest_q;
  logic        ex_load_q, mem_load_q;
  logic [2:0]  ex_rs1_q, ex_rs2_q;
  logic [15:0] stall_cnt_q;

  logic [3:0] opcode;
  logic       is_alu, is_addi, is_ld, is_st, is_bz;
  logic       use_rs1, use_rs2, wb_en;
  logic [2:0] rs1, rs2;
  logic       load_use, branch_haz, stall;

  // Immediate/unused low bits of the instruction word
  logic unused_instr_bits;
  assign unused_instr_bits = ^id_instr[2:0];

  always_comb begin
    opcode  = id_instr[15:12];
    is_alu  = (opcode >= 4'd1) && (opcode <= 4'd8);
    is_addi = (opcode == OpAddi);
    is_ld   = (opcode == OpLd);
    is_st   = (opcode == OpSt);
    is_bz   = (opcode == OpBz);
    use_rs1 = is_alu | is_addi | is_ld | is_st | is_bz;
    use_rs2 = is_alu | is_st;
    wb_en   = (opcode >= 4'd1) && (opcode <= 4'd10);
    rs1     = id_instr[8:6];
    rs2     = is_st ? id_instr[11:9] : id_instr[5:3];
  end

  always_comb begin
    load_use   = ex_valid_q & ex_load_q &
                 ((use_rs1 & (ex_dest_q == rs1)) | (use_rs2 & (ex_dest_q == rs2)));
    branch_haz = is_bz & ((ex_valid_q & (ex_dest_q == rs1)) |
                          (mem_valid_q & mem_load_q & (mem_dest_q == rs1)));
    stall      = load_use | branch_haz;
  end

  // Outputs are forced low while reset is held, whatever the decode inputs show
  always_comb begin
    pc_stall    = ~rst & (stall | mem_busy);
    ifid_stall  = ~rst & (stall | mem_busy);
    idex_bubble = ~rst & stall & ~mem_busy;
    ifid_flush  = ~rst & ~mem_busy & id_branch_taken & is_bz & ~stall;
  end

  always_comb begin
    fwd_rs1 = FwdRf;
    if (mem_valid_q && !mem_load_q && (mem_dest_q == ex_rs1_q)) begin
      fwd_rs1 = FwdMem;
    end else if (wb_valid_q && (wb_dest_q == ex_rs1_q)) begin
      fwd_rs1 = FwdWb;
    end
    fwd_rs2 = FwdRf;
    if (mem_valid_q && !mem_load_q && (mem_dest_q == ex_rs2_q)) begin
      fwd_rs2 = FwdMem;
    end else if (wb_valid_q && (wb_dest_q == ex_rs2_q)) begin
      fwd_rs2 = FwdWb;
    end
  end

  assign stall_count = stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_dest_q   <= 3'd0;
      ex_load_q   <= 1'b0;
      ex_rs1_q    <= 3'd0;
      ex_rs2_q    <= 3'd0;
      mem_valid_q <= 1'b0;
      mem_dest_q  <= 3'd0;
      mem_load_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= 3'd0;
      stall_cnt_q <= 16'd0;
    end else if (!mem_busy) begin
      wb_valid_q  <= mem_valid_q;
      wb_dest_q   <= mem_dest_q;
      mem_valid_q <= ex_valid_q;
      mem_dest_q  <= ex_dest_q;
      mem_load_q  <= ex_load_q;
      if (stall) begin
        ex_valid_q <= 1'b0;
        ex_dest_q  <= 3'd0;
        ex_load_q  <= 1'b0;
        ex_rs1_q   <= 3'd0;
        ex_rs2_q   <= 3'd0;
      end else begin
        ex_valid_q <= wb_en;
        ex_dest_q  <= id_dest;
        ex_load_q  <= is_ld;
        ex_rs1_q   <= rs1;
        ex_rs2_q   <= rs2;
      end
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

endmodule
